ten_gig_mac_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares the 10G MAC TX AXI-Stream

---
 rtl/ten_gig_mac_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_ten_gig_mac_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ten_gig_mac_tx_arbiter.sv
// Packet-level round-robin arbiter that shares the 10G MAC TX AXI-Stream input
// between two requesters, with an inter-packet idle gap and a runaway-packet watchdog.
module ten_gig_mac_tx_arbiter #(
  parameter int unsigned P_GAP_CYCLES = 1,
  parameter int unsigned P_MAX_BEATS  = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s0_axis_tdata,
  input  logic [79:0] s0_axis_tuser,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [63:0] s1_axis_tdata,
  input  logic [79:0] s1_axis_tuser,
  input  logic [7:0]  s1_axis_tkeep,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [79:0] m_axis_tuser,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [1:0]  o_grant,
  output logic        o_trunc,
  output logic [31:0] o_pkt_cnt0,
  output logic [31:0] o_pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP, GAP} state_t;

  localparam logic [3:0]  GAP_LOAD  = (P_GAP_CYCLES == 0) ? 4'd0 : 4'(P_GAP_CYCLES - 1);
  localparam state_t      POST_PKT  = (P_GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [16:0] MAX_BEATS = 17'(P_MAX_BEATS);

  state_t      state;
  logic        rr_ptr;      // 0: port0 wins a tie, 1: port1 wins a tie
  logic [15:0] beat_cnt;
  logic [3:0]  gap_cnt;

  logic        sel;
  logic [63:0] sel_tdata;
  logic [79:0] sel_tuser;
  logic [7:0]  sel_tkeep;
  logic        sel_tlast;
  logic        sel_tvalid;
  logic        wd_hit;
  logic        xfer;

  assign sel = o_grant[1];

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_tdata  = s0_axis_tdata;
    sel_tuser  = s0_axis_tuser;
    sel_tkeep  = s0_axis_tkeep;
    sel_tlast  = s0_axis_tlast;
    sel_tvalid = s0_axis_tvalid;
    if (sel) begin
      sel_tdata  = s1_axis_tdata;
      sel_tuser  = s1_axis_tuser;
      sel_tkeep  = s1_axis_tkeep;
      sel_tlast  = s1_axis_tlast;
      sel_tvalid = s1_axis_tvalid;
    end
  end

  // True while the beat currently offered would be beat number P_MAX_BEATS.
  assign wd_hit = ({1'b0, beat_cnt} + 17'd1) == MAX_BEATS;

  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tuser   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      BUSY: begin
        m_axis_tdata   = sel_tdata;
        m_axis_tuser   = sel_tuser;
        m_axis_tkeep   = sel_tkeep;
        m_axis_tlast   = sel_tlast | wd_hit;
        m_axis_tvalid  = sel_tvalid;
        s0_axis_tready = ~sel & m_axis_tready;
        s1_axis_tready = sel & m_axis_tready;
      end
      DROP: begin
        s0_axis_tready = ~sel;
        s1_axis_tready = sel;
      end
      default: ;
    endcase
  end

  assign xfer = (state == BUSY) && sel_tvalid && m_axis_tready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      o_grant    <= 2'b00;
      o_trunc    <= 1'b0;
      o_pkt_cnt0 <= '0;
      o_pkt_cnt1 <= '0;
    end else begin
      o_trunc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            if (s0_axis_tvalid && s1_axis_tvalid) begin
              o_grant <= rr_ptr ? 2'b10 : 2'b01;
              rr_ptr  <= ~rr_ptr;
            end else begin
              o_grant <= s0_axis_tvalid ? 2'b01 : 2'b10;
            end
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (sel_tlast) begin
              if (sel) o_pkt_cnt1 <= o_pkt_cnt1 + 32'd1;
              else     o_pkt_cnt0 <= o_pkt_cnt0 + 32'd1;
              o_grant <= 2'b00;
              gap_cnt <= GAP_LOAD;
              state   <= POST_PKT;
            end else if (wd_hit) begin
              o_trunc <= 1'b1;
              state   <= DROP;
            end
          end
        end
        DROP: begin
          if (sel_tvalid && sel_tlast) begin
            o_grant <= 2'b00;
            gap_cnt <= GAP_LOAD;
            state   <= POST_PKT;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ten_gig_mac_tx_arbiter.sv
// Directed self-checking bench for ten_gig_mac_tx_arbiter: arbitration order,
// backpressure, watchdog truncation, exact-limit completion and async reset.
module tb_ten_gig_mac_tx_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [63:0] s0_axis_tdata,  s1_axis_tdata,  m_axis_tdata;
  logic [79:0] s0_axis_tuser,  s1_axis_tuser,  m_axis_tuser;
  logic [7:0]  s0_axis_tkeep,  s1_axis_tkeep,  m_axis_tkeep;
  logic        s0_axis_tlast,  s1_axis_tlast,  m_axis_tlast;
  logic        s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic        s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic [1:0]  o_grant;
  logic        o_trunc;
  logic [31:0] o_pkt_cnt0, o_pkt_cnt1;

  int checks = 0;
  int errors = 0;
  logic [64:0] out_q[$];
  logic [64:0] exp_q[$];

  ten_gig_mac_tx_arbiter #(.P_GAP_CYCLES(1), .P_MAX_BEATS(256)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tuser(s0_axis_tuser), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tuser(s1_axis_tuser), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .o_grant(o_grant), .o_trunc(o_trunc), .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int port, input int pkt, input int beat);
    return 64'hA5A5_0000_0000_0000 | (64'(port) << 40) | (64'(pkt) << 24) | 64'(beat);
  endfunction
  function automatic logic [7:0]  kp(input logic [63:0] d); return d[7:0] ^ 8'h3C; endfunction
  function automatic logic [79:0] us(input logic [63:0] d); return {d[15:0], ~d}; endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit valid, input bit last, input logic [63:0] d);
    if (!port) begin
      s0_axis_tvalid = valid; s0_axis_tlast = last; s0_axis_tdata = d;
      s0_axis_tkeep  = kp(d); s0_axis_tuser = us(d);
    end else begin
      s1_axis_tvalid = valid; s1_axis_tlast = last; s1_axis_tdata = d;
      s1_axis_tkeep  = kp(d); s1_axis_tuser = us(d);
    end
  endtask

  task automatic apply_reset();
    i_rst = 1'b0;
    drive(0, 0, 0, '0);
    drive(1, 0, 0, '0);
    m_axis_tready = 1'b1;
    repeat (2) tick();
    i_rst = 1'b1;
  endtask

  // Fixed-length packets from either port; records every output handshake as {tlast, tdata}.
  task automatic run_traffic(input string tag, input int n0, input int n1, input int len,
                             input bit toggle, input int budget);
    int  sent[2];
    int  beat[2];
    int  cyc;
    bit  h0, h1;
    sent = '{0, 0};
    beat = '{0, 0};
    cyc  = 0;
    out_q.delete();
    while ((sent[0] < n0 || sent[1] < n1) && cyc < budget) begin
      drive(0, sent[0] < n0, beat[0] == len - 1, mk(0, sent[0], beat[0]));
      drive(1, sent[1] < n1, beat[1] == len - 1, mk(1, sent[1], beat[1]));
      m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      h0 = s0_axis_tvalid && s0_axis_tready;
      h1 = s1_axis_tvalid && s1_axis_tready;
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      if (o_grant == 2'b10 && m_axis_tvalid)
        check({tag, "_s1_ready_mirror"}, 128'(s1_axis_tready), 128'(m_axis_tready));
      tick();
      if (h0) begin if (beat[0] == len - 1) begin beat[0] = 0; sent[0]++; end else beat[0]++; end
      if (h1) begin if (beat[1] == len - 1) begin beat[1] = 0; sent[1]++; end else beat[1]++; end
      cyc++;
    end
    check({tag, "_in_budget"}, 128'(cyc < budget), 128'(1));
    drive(0, 0, 0, '0);
    drive(1, 0, 0, '0);
    m_axis_tready = 1'b1;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_len"}, 128'(out_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, 128'((i < out_q.size()) ? out_q[i] : 65'h0), 128'(exp_q[i]));
  endtask

  // One long packet on port 0 with tlast on its final input beat, plus three trailing idle cycles.
  task automatic run_long(input int nbeats, input int pkt, input int budget,
                          output int out_beats, output int last_at, output logic [63:0] last_data,
                          output int trunc_cnt, output int trunc_lag, output int consumed);
    int cyc;
    int tail;
    int last_out_cyc;
    bit h;
    out_beats = 0; last_at = 0; last_data = '0; trunc_cnt = 0; trunc_lag = -1;
    consumed = 0; cyc = 0; tail = 0; last_out_cyc = -10;
    m_axis_tready = 1'b1;
    while (cyc < budget && tail < 3) begin
      if (consumed < nbeats) drive(0, 1, consumed == nbeats - 1, mk(0, pkt, consumed));
      else begin drive(0, 0, 0, '0); tail++; end
      #1;
      if (o_trunc) begin trunc_cnt++; trunc_lag = cyc - last_out_cyc; end
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        last_out_cyc = cyc;
        if (m_axis_tlast && last_at == 0) begin last_at = out_beats; last_data = m_axis_tdata; end
      end
      h = s0_axis_tvalid && s0_axis_tready;
      tick();
      if (h) consumed++;
      cyc++;
    end
  endtask

  initial begin
    int          ob, la, tc, tl, cons;
    logic [63:0] ld;

    // Reset state, with requests already pending
    i_rst = 1'b0;
    drive(0, 1, 0, mk(0, 9, 0));
    drive(1, 1, 0, mk(1, 9, 0));
    m_axis_tready = 1'b1;
    repeat (2) tick();
    #1;
    check("rst_grant",  128'(o_grant), 128'(2'b00));
    check("rst_mvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_rdy0",   128'(s0_axis_tready), 128'(0));
    check("rst_rdy1",   128'(s1_axis_tready), 128'(0));
    check("rst_trunc",  128'(o_trunc), 128'(0));
    check("rst_cnt0",   128'(o_pkt_cnt0), 128'(0));
    check("rst_cnt1",   128'(o_pkt_cnt1), 128'(0));
    apply_reset();

    // 1: single 3-beat packet on port 0
    drive(0, 1, 0, mk(0, 0, 0));
    #1;
    check("t1_idle_grant", 128'(o_grant), 128'(2'b00));
    check("t1_idle_mvalid", 128'(m_axis_tvalid), 128'(0));
    tick();
    #1;
    check("t1_grant",  128'(o_grant), 128'(2'b01));
    check("t1_b0_data", 128'(m_axis_tdata), 128'(mk(0, 0, 0)));
    check("t1_b0_keep", 128'(m_axis_tkeep), 128'(kp(mk(0, 0, 0))));
    check("t1_b0_user", 128'(m_axis_tuser), 128'(us(mk(0, 0, 0))));
    check("t1_b0_valid", 128'(m_axis_tvalid), 128'(1));
    check("t1_rdy0", 128'(s0_axis_tready), 128'(1));
    check("t1_rdy1", 128'(s1_axis_tready), 128'(0));
    tick();
    drive(0, 1, 0, mk(0, 0, 1));
    #1;
    check("t1_b1_data", 128'(m_axis_tdata), 128'(mk(0, 0, 1)));
    check("t1_b1_last", 128'(m_axis_tlast), 128'(0));
    tick();
    drive(0, 1, 1, mk(0, 0, 2));
    #1;
    check("t1_b2_data", 128'(m_axis_tdata), 128'(mk(0, 0, 2)));
    check("t1_b2_last", 128'(m_axis_tlast), 128'(1));
    tick();
    drive(0, 1, 0, mk(0, 1, 0));
    #1;
    check("t1_cnt0", 128'(o_pkt_cnt0), 128'(1));
    check("t1_gap_grant", 128'(o_grant), 128'(2'b00));
    check("t1_gap_mvalid", 128'(m_axis_tvalid), 128'(0));
    check("t1_gap_rdy0", 128'(s0_axis_tready), 128'(0));
    tick();
    check("t1_idle2_grant", 128'(o_grant), 128'(2'b00));
    tick();
    check("t1_regrant", 128'(o_grant), 128'(2'b01));

    // 2: both ports contend from reset with 2-beat packets
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 2; b++)
        exp_q.push_back({(b == 1), mk(k % 2, k / 2, b)});
    run_traffic("t2", 2, 2, 2, 1'b0, 60);
    compare_q("t2_order");
    check("t2_cnt0", 128'(o_pkt_cnt0), 128'(2));
    check("t2_cnt1", 128'(o_pkt_cnt1), 128'(2));

    // 3: port 1 packet under toggling backpressure
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back({(b == 3), mk(1, 0, b)});
    run_traffic("t3", 0, 1, 4, 1'b1, 40);
    compare_q("t3_order");
    check("t3_cnt1", 128'(o_pkt_cnt1), 128'(3));

    // 4: 300-beat runaway packet is cut at beat 256
    run_long(300, 4, 400, ob, la, ld, tc, tl, cons);
    check("t4_consumed",  128'(cons), 128'(300));
    check("t4_out_beats", 128'(ob), 128'(256));
    check("t4_last_at",   128'(la), 128'(256));
    check("t4_last_data", 128'(ld), 128'(mk(0, 4, 255)));
    check("t4_trunc_cnt", 128'(tc), 128'(1));
    check("t4_trunc_lag", 128'(tl), 128'(1));
    check("t4_cnt0",      128'(o_pkt_cnt0), 128'(2));

    // 5: packet ending exactly on beat 256 completes normally
    run_long(256, 5, 320, ob, la, ld, tc, tl, cons);
    check("t5_out_beats", 128'(ob), 128'(256));
    check("t5_last_at",   128'(la), 128'(256));
    check("t5_last_data", 128'(ld), 128'(mk(0, 5, 255)));
    check("t5_trunc_cnt", 128'(tc), 128'(0));
    check("t5_cnt0",      128'(o_pkt_cnt0), 128'(3));

    // 6: asynchronous reset on beat 2 of a 5-beat packet
    drive(0, 1, 0, mk(0, 6, 0));
    tick();
    tick();
    tick();
    #1;
    check("t6_pre_grant", 128'(o_grant), 128'(2'b01));
    tick();
    drive(0, 1, 0, mk(0, 6, 1));
    #1;
    check("t6_b1_data", 128'(m_axis_tdata), 128'(mk(0, 6, 1)));
    i_rst = 1'b0;
    #1;
    check("t6_mvalid", 128'(m_axis_tvalid), 128'(0));
    check("t6_mdata",  128'(m_axis_tdata), 128'(0));
    check("t6_mlast",  128'(m_axis_tlast), 128'(0));
    check("t6_grant",  128'(o_grant), 128'(2'b00));
    check("t6_rdy0",   128'(s0_axis_tready), 128'(0));
    check("t6_cnt0",   128'(o_pkt_cnt0), 128'(0));
    check("t6_cnt1",   128'(o_pkt_cnt1), 128'(0));
    drive(1, 1, 0, mk(1, 6, 0));
    tick();
    i_rst = 1'b1;
    #1;
    check("t6_rel_grant", 128'(o_grant), 128'(2'b00));
    tick();
    check("t6_port0_pref", 128'(o_grant), 128'(2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
